dac_cal_sequencer: RTL and testbench
====================================

DAC_CAL_SEQUENCER -- requirements
Module: dac_cal_sequencer

Interface
REQ-001 Parameter: ctrl_reg_addr, default 0, GPIO address of the control register.
REQ-002 Parameter: settle_cycles, default 64, wait after every mux/shift change before triggering (range 1..65535).
REQ-003 Parameter: timeout_cycles, default 4096, maximum wait for adc_hit after a trigger (range 1..65535).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 gpio_in  input  32  GPIO bus: [15:0] address, [23:16] data, [24] w_clk.
REQ-007 adc_hit  input  1  one-cycle pulse, calibration edge detected at ADC.
REQ-008 adc_hit_pos  input  4  sample index (0..15) of detected edge within the 16-sample word, valid with adc_hit.
REQ-009 dac_mux_sel  output  8  DAC source select (0 = FSM path, 1 = static word, 2 = delay-cal word).
REQ-010 shift_amt  output  4  output shifter sample shift.
REQ-011 del_trig  output  1  one-cycle delay-cal trigger pulse.
REQ-012 cal_busy  output  1  high while a sweep is in progress.
REQ-013 cal_done  output  1  sticky, calibration succeeded.
REQ-014 cal_fail  output  1  sticky, calibration failed.
REQ-015 cal_latency  output  16  clk cycles from del_trig to adc_hit for the winning shift.

Function
REQ-016 A GPIO write is a 0->1 edge of gpio_in[24], detected on registered samples, with gpio_in[15:0] == ctrl_reg_addr; data bit 16 = start, bit 17 = abort.
REQ-017 States: IDLE, SETUP, SETTLE, TRIG, WAIT, EVAL, DONE, FAIL.
REQ-018 IDLE/DONE/FAIL + start: clear cal_done, cal_fail, cal_latency; index := 0; go to SETUP; cal_busy = 1 from the next cycle.
REQ-019 SETUP (1 cycle): dac_mux_sel := 2, shift_amt := index, latency counter := 0; go to SETTLE.
REQ-020 SETTLE: count exactly settle_cycles cycles, then go to TRIG.
REQ-021 TRIG (1 cycle): del_trig = 1; go to WAIT; del_trig is 0 in every other state.
REQ-022 WAIT: latency counter increments each cycle, reaching 1 on the first WAIT cycle; adc_hit ends WAIT and latches hit flag, adc_hit_pos, and counter; counter reaching timeout_cycles without hit ends WAIT with hit flag = 0.
REQ-023 adc_hit outside WAIT is ignored.
REQ-024 EVAL (1 cycle): hit with pos == 0 -> DONE; else index == 15 -> FAIL; else index := index + 1, go to SETUP.
REQ-025 DONE: cal_busy = 0, cal_done = 1, cal_latency = latched counter, shift_amt = winning index, dac_mux_sel := 0.
REQ-026 FAIL: cal_busy = 0, cal_fail = 1, shift_amt := 0, dac_mux_sel := 1.
REQ-027 Abort in any busy state: next state IDLE, dac_mux_sel := 0, shift_amt := 0, cal_busy = 0, done/fail unchanged (cleared by the preceding start).
REQ-028 Start and abort in the same write: abort wins.
REQ-029 Start while busy is ignored.
REQ-030 Abort in IDLE/DONE/FAIL is ignored.
REQ-031 Writes to other addresses have no effect.
REQ-032 The index never wraps; at most 16 iterations per sweep.
REQ-033 All outputs are registered.

Reset
REQ-034 On rst: state IDLE, dac_mux_sel = 0, shift_amt = 0, del_trig = 0, cal_busy = 0, cal_done = 0, cal_fail = 0, cal_latency = 0, edge-detect register = 0.
REQ-035 rst mid-sweep immediately returns to these values; no del_trig is issued until a new start.

Verification
REQ-036 Start; model returns adc_hit 37 cycles after each del_trig, pos = 3,2,1,0 for index 0..3 -> four del_trig pulses spaced settle + 40 cycles apart; cal_done = 1, shift_amt = 3, cal_latency = 37, dac_mux_sel = 0.
REQ-037 Start, no adc_hit ever -> 16 triggers, each WAIT lasting 4096 cycles; cal_fail = 1, shift_amt = 0, dac_mux_sel = 1.
REQ-038 Abort write during the WAIT of index 5 -> IDLE next cycle, cal_busy = 0, dac_mux_sel = 0, done = fail = 0.
REQ-039 Start + abort in one write -> no state change; start to address ctrl_reg_addr + 1 -> no state change; second start mid-sweep -> sweep continues unchanged.
REQ-040 rst asserted during SETTLE of index 7 -> all outputs at reset values asynchronously; after release, a fresh start sweeps from index 0.
REQ-041 adc_hit pulsed during SETTLE and IDLE -> ignored, latency measured from the next TRIG only.

Source files
------------

// File: rtl/dac_cal_sequencer.sv
// Purpose: sweeps the DAC output shift 0..15, triggering a delay-cal word and timing the ADC echo.
// Latency: a GPIO control write takes effect 2 cycles after the w_clk rising edge; outputs are registered.
// Backpressure: none; adc_hit is only sampled while waiting on a trigger, otherwise dropped.
module dac_cal_sequencer #(
    parameter int ctrl_reg_addr  = 0,
    parameter int settle_cycles  = 64,
    parameter int timeout_cycles = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_in,
    input  logic        adc_hit,
    input  logic [3:0]  adc_hit_pos,
    output logic [7:0]  dac_mux_sel,
    output logic [3:0]  shift_amt,
    output logic        del_trig,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_fail,
    output logic [15:0] cal_latency
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SETTLE,
        S_TRIG,
        S_WAIT,
        S_EVAL,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [15:0] LP_ADDR        = 16'(ctrl_reg_addr);
    localparam logic [15:0] LP_SETTLE_LAST = 16'(settle_cycles - 1);
    localparam logic [15:0] LP_TIMEOUT     = 16'(timeout_cycles);

    localparam logic [7:0]  LP_MUX_FSM     = 8'd0;
    localparam logic [7:0]  LP_MUX_STATIC  = 8'd1;
    localparam logic [7:0]  LP_MUX_DELCAL  = 8'd2;

    // Only address, start/abort and w_clk of the GPIO bus matter here.
    logic w_unused;
    assign w_unused = ^{gpio_in[31:25], gpio_in[23:18]};

    state_t      r_state, w_nstate;
    logic        r_wclk_d, r_wclk_q;
    logic [15:0] r_addr_d;
    logic        r_start_d, r_abort_d;
    logic [3:0]  r_index, w_nindex;
    logic [15:0] r_settle_cnt, w_nsettle;
    logic [15:0] r_lat_cnt, w_nlat;
    logic        r_hit, w_nhit;
    logic [3:0]  r_hit_pos, w_npos;
    logic [7:0]  r_dac_mux_sel, w_nmux;
    logic [3:0]  r_shift_amt, w_nshift;
    logic        r_del_trig;
    logic        r_cal_busy;
    logic        r_cal_done, w_ndone;
    logic        r_cal_fail, w_nfail;
    logic [15:0] r_cal_latency, w_nlatency;

    logic        w_wr, w_start, w_abort, w_busy, w_nbusy;
    logic [15:0] w_lat_inc;

    // Write strobe is the rising edge of the registered w_clk at our address.
    assign w_wr      = r_wclk_d & ~r_wclk_q & (r_addr_d == LP_ADDR);
    assign w_start   = w_wr & r_start_d;
    assign w_abort   = w_wr & r_abort_d;
    assign w_busy    = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FAIL);
    assign w_nbusy   = (w_nstate != S_IDLE) && (w_nstate != S_DONE) && (w_nstate != S_FAIL);
    assign w_lat_inc = r_lat_cnt + 16'd1;

    // Sample the GPIO bus and keep the previous w_clk for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wclk_d  <= 1'b0;
            r_wclk_q  <= 1'b0;
            r_addr_d  <= 16'd0;
            r_start_d <= 1'b0;
            r_abort_d <= 1'b0;
        end else begin
            r_wclk_d  <= gpio_in[24];
            r_wclk_q  <= r_wclk_d;
            r_addr_d  <= gpio_in[15:0];
            r_start_d <= gpio_in[16];
            r_abort_d <= gpio_in[17];
        end
    end

    // Next-state and next-output logic of the sweep FSM.
    always_comb begin
        w_nstate   = r_state;
        w_nindex   = r_index;
        w_nsettle  = r_settle_cnt;
        w_nlat     = r_lat_cnt;
        w_nhit     = r_hit;
        w_npos     = r_hit_pos;
        w_nmux     = r_dac_mux_sel;
        w_nshift   = r_shift_amt;
        w_ndone    = r_cal_done;
        w_nfail    = r_cal_fail;
        w_nlatency = r_cal_latency;

        if (w_busy && w_abort) begin
            // Abort beats everything, including a start in the same write.
            w_nstate = S_IDLE;
            w_nmux   = LP_MUX_FSM;
            w_nshift = 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (w_start && !w_abort) begin
                        w_ndone    = 1'b0;
                        w_nfail    = 1'b0;
                        w_nlatency = 16'd0;
                        w_nindex   = 4'd0;
                        w_nstate   = S_SETUP;
                    end
                end
                S_SETUP: begin
                    w_nmux    = LP_MUX_DELCAL;
                    w_nshift  = r_index;
                    w_nlat    = 16'd0;
                    w_nsettle = 16'd0;
                    w_nstate  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == LP_SETTLE_LAST) begin
                        w_nstate = S_TRIG;
                    end else begin
                        w_nsettle = r_settle_cnt + 16'd1;
                    end
                end
                S_TRIG: begin
                    w_nstate = S_WAIT;
                end
                S_WAIT: begin
                    // Counter reads 1 on the first WAIT cycle; a hit freezes it.
                    w_nlat = w_lat_inc;
                    if (adc_hit) begin
                        w_nhit   = 1'b1;
                        w_npos   = adc_hit_pos;
                        w_nstate = S_EVAL;
                    end else if (w_lat_inc == LP_TIMEOUT) begin
                        w_nhit   = 1'b0;
                        w_nstate = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (r_hit && (r_hit_pos == 4'd0)) begin
                        w_nstate   = S_DONE;
                        w_ndone    = 1'b1;
                        w_nlatency = r_lat_cnt;
                        w_nshift   = r_index;
                        w_nmux     = LP_MUX_FSM;
                    end else if (r_index == 4'd15) begin
                        w_nstate = S_FAIL;
                        w_nfail  = 1'b1;
                        w_nshift = 4'd0;
                        w_nmux   = LP_MUX_STATIC;
                    end else begin
                        w_nindex = r_index + 4'd1;
                        w_nstate = S_SETUP;
                    end
                end
                default: begin
                    w_nstate = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; trigger and busy follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_index       <= 4'd0;
            r_settle_cnt  <= 16'd0;
            r_lat_cnt     <= 16'd0;
            r_hit         <= 1'b0;
            r_hit_pos     <= 4'd0;
            r_dac_mux_sel <= LP_MUX_FSM;
            r_shift_amt   <= 4'd0;
            r_del_trig    <= 1'b0;
            r_cal_busy    <= 1'b0;
            r_cal_done    <= 1'b0;
            r_cal_fail    <= 1'b0;
            r_cal_latency <= 16'd0;
        end else begin
            r_state       <= w_nstate;
            r_index       <= w_nindex;
            r_settle_cnt  <= w_nsettle;
            r_lat_cnt     <= w_nlat;
            r_hit         <= w_nhit;
            r_hit_pos     <= w_npos;
            r_dac_mux_sel <= w_nmux;
            r_shift_amt   <= w_nshift;
            r_del_trig    <= (w_nstate == S_TRIG);
            r_cal_busy    <= w_nbusy;
            r_cal_done    <= w_ndone;
            r_cal_fail    <= w_nfail;
            r_cal_latency <= w_nlatency;
        end
    end

    assign dac_mux_sel = r_dac_mux_sel;
    assign shift_amt   = r_shift_amt;
    assign del_trig    = r_del_trig;
    assign cal_busy    = r_cal_busy;
    assign cal_done    = r_cal_done;
    assign cal_fail    = r_cal_fail;
    assign cal_latency = r_cal_latency;

endmodule

// File: tb/tb_dac_cal_sequencer.sv
// Purpose: self-checking bench for dac_cal_sequencer with an ADC echo model and trigger scoreboard.
// Latency: echo model answers each del_trig 37 cycles later when enabled.
// Backpressure: not applicable; bench drives GPIO writes and adc_hit directly.
module tb_dac_cal_sequencer;

    localparam int S  = 64;
    localparam int TO = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_in = 32'd0;
    logic        adc_hit;
    logic [3:0]  adc_hit_pos;
    logic [7:0]  dac_mux_sel;
    logic [3:0]  shift_amt;
    logic        del_trig;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [15:0] cal_latency;

    logic        resp_hit = 1'b0;
    logic [3:0]  resp_pos = 4'd0;
    logic        man_hit  = 1'b0;

    assign adc_hit     = resp_hit | man_hit;
    assign adc_hit_pos = resp_hit ? resp_pos : 4'd0;

    dac_cal_sequencer #(
        .ctrl_reg_addr (0),
        .settle_cycles (S),
        .timeout_cycles(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_in    (gpio_in),
        .adc_hit    (adc_hit),
        .adc_hit_pos(adc_hit_pos),
        .dac_mux_sel(dac_mux_sel),
        .shift_amt  (shift_amt),
        .del_trig   (del_trig),
        .cal_busy   (cal_busy),
        .cal_done   (cal_done),
        .cal_fail   (cal_fail),
        .cal_latency(cal_latency)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int trig_cnt = 0;
    int last_trig_cyc = 0;
    // echo mode: 0 -> pos = 3 - shift, 1 -> pos = 1, 2 -> silent, 3 -> pos = 0
    int mode = 2;

    typedef struct {
        int shift;
        int gap;
    } trig_t;
    trig_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every del_trig pops the shift and spacing expected of it.
    initial begin
        trig_t e;
        forever begin
            @(negedge clk);
            if (!rst && del_trig) begin
                trig_cnt++;
                chk("trig_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("trig_shift", int'(shift_amt), e.shift);
                    chk("trig_mux", int'(dac_mux_sel), 2);
                    if (e.gap != 0) chk("trig_gap", cyc - last_trig_cyc, e.gap);
                end
                last_trig_cyc = cyc;
            end
        end
    end

    // ADC echo model: one-cycle hit 37 cycles after a trigger.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && del_trig && mode != 2) begin
                repeat (37) @(negedge clk);
                case (mode)
                    0:       resp_pos = 4'(3 - int'(shift_amt));
                    1:       resp_pos = 4'd1;
                    default: resp_pos = 4'd0;
                endcase
                resp_hit = 1'b1;
                @(negedge clk);
                resp_hit = 1'b0;
            end
        end
    end

    task automatic gpio_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        gpio_in = {7'd0, 1'b1, d, a};
        @(posedge clk); #1;
        @(posedge clk); #1;
        gpio_in[24] = 1'b0;
    endtask

    task automatic push_trigs(input int n, input int gap);
        for (int i = 0; i < n; i++) exp_q.push_back('{shift: i, gap: (i == 0) ? 0 : gap});
    endtask

    task automatic wait_trigs(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (trig_cnt < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (trig_cnt < target) chk({name, "_timeout"}, trig_cnt, target);
    endtask

    task automatic wait_end(input int budget, input string name);
        int k;
        k = 0;
        while (!(cal_done || cal_fail) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(cal_done || cal_fail)) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_man_hit();
        @(negedge clk);
        man_hit = 1'b1;
        @(negedge clk);
        man_hit = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          exp_busy;
        int          exp_mux;
        string       name;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int base;
        int k;

        vecs[0] = '{16'h0000, 8'h03, 0, 0, "start_abort"};
        vecs[1] = '{16'h0001, 8'h01, 0, 0, "other_addr"};
        vecs[2] = '{16'h0000, 8'h02, 0, 0, "abort_idle"};
        vecs[3] = '{16'hFFFF, 8'h01, 0, 0, "far_addr"};
        vecs[4] = '{16'h0000, 8'hFC, 0, 0, "no_cmd_bits"};
        vecs[5] = '{16'h0000, 8'h01, 1, 2, "start"};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(cal_busy), 0);
        chk("rst_mux", int'(dac_mux_sel), 0);
        chk("rst_trig", int'(del_trig), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_shift", int'(shift_amt), 0);
        chk("post_rst_done", int'(cal_done), 0);
        chk("post_rst_fail", int'(cal_fail), 0);
        chk("post_rst_lat", int'(cal_latency), 0);

        // Control-write decode table, all from IDLE
        for (int i = 0; i < 6; i++) begin
            gpio_write(vecs[i].addr, vecs[i].data);
            repeat (2) @(posedge clk);
            #1;
            chk({vecs[i].name, "_busy"}, int'(cal_busy), vecs[i].exp_busy);
            chk({vecs[i].name, "_mux"}, int'(dac_mux_sel), vecs[i].exp_mux);
            chk({vecs[i].name, "_shift"}, int'(shift_amt), 0);
            if (vecs[i].exp_busy != 0) begin
                gpio_write(16'h0000, 8'h02);
                chk({vecs[i].name, "_abort_busy"}, int'(cal_busy), 0);
                chk({vecs[i].name, "_abort_mux"}, int'(dac_mux_sel), 0);
            end
        end

        // Four-iteration sweep, winner at shift 3; a second start mid-sweep is ignored
        mode = 0;
        base = trig_cnt;
        push_trigs(4, S + 40);
        gpio_write(16'h0000, 8'h01);
        wait_trigs(base + 2, 1000, "sweep_t2");
        gpio_write(16'h0000, 8'h01);
        wait_end(1000, "sweep");
        chk("sweep_done", int'(cal_done), 1);
        chk("sweep_fail", int'(cal_fail), 0);
        chk("sweep_busy", int'(cal_busy), 0);
        chk("sweep_shift", int'(shift_amt), 3);
        chk("sweep_latency", int'(cal_latency), 37);
        chk("sweep_mux", int'(dac_mux_sel), 0);
        chk("sweep_trigs", trig_cnt - base, 4);

        // Abort while DONE is ignored
        gpio_write(16'h0000, 8'h02);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_done_keep", int'(cal_done), 1);
        chk("abort_done_shift", int'(shift_amt), 3);

        // Abort during WAIT of index 5
        mode = 1;
        base = trig_cnt;
        push_trigs(6, S + 40);
        gpio_write(16'h0000, 8'h01);
        chk("restart_clears_done", int'(cal_done), 0);
        wait_trigs(base + 6, 2000, "abort_t6");
        repeat (10) @(posedge clk);
        gpio_write(16'h0000, 8'h02);
        chk("abort_busy", int'(cal_busy), 0);
        chk("abort_mux", int'(dac_mux_sel), 0);
        chk("abort_shift", int'(shift_amt), 0);
        chk("abort_done", int'(cal_done), 0);
        chk("abort_fail", int'(cal_fail), 0);
        repeat (150) @(posedge clk);
        #1;
        chk("abort_no_more_trigs", trig_cnt - base, 6);
        chk("abort_still_idle", int'(cal_busy), 0);

        // Async reset during SETTLE of index 7
        base = trig_cnt;
        push_trigs(7, S + 40);
        gpio_write(16'h0000, 8'h01);
        wait_trigs(base + 7, 2000, "rst_t7");
        k = 0;
        while (shift_amt != 4'd7 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_reached_idx7", int'(shift_amt), 7);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(cal_busy), 0);
        chk("arst_mux", int'(dac_mux_sel), 0);
        chk("arst_shift", int'(shift_amt), 0);
        chk("arst_trig", int'(del_trig), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("arst_no_trig", trig_cnt - base, 7);
        chk("arst_idle", int'(cal_busy), 0);

        // Stray hits in IDLE and SETTLE are ignored; fresh sweep starts at index 0
        mode = 3;
        base = trig_cnt;
        pulse_man_hit();
        push_trigs(1, 0);
        gpio_write(16'h0000, 8'h01);
        repeat (10) @(posedge clk);
        pulse_man_hit();
        wait_end(1000, "fresh");
        chk("fresh_done", int'(cal_done), 1);
        chk("fresh_shift", int'(shift_amt), 0);
        chk("fresh_latency", int'(cal_latency), 37);
        chk("fresh_trigs", trig_cnt - base, 1);

        // No echo at all: 16 full timeouts then FAIL
        mode = 2;
        base = trig_cnt;
        push_trigs(16, S + TO + 3);
        gpio_write(16'h0000, 8'h01);
        wait_end(70000, "timeout");
        chk("to_fail", int'(cal_fail), 1);
        chk("to_done", int'(cal_done), 0);
        chk("to_busy", int'(cal_busy), 0);
        chk("to_shift", int'(shift_amt), 0);
        chk("to_mux", int'(dac_mux_sel), 1);
        chk("to_trigs", trig_cnt - base, 16);
        chk("to_queue_empty", exp_q.size(), 0);

        // Start from FAIL clears the sticky fail
        gpio_write(16'h0000, 8'h01);
        chk("restart_clears_fail", int'(cal_fail), 0);
        chk("restart_busy", int'(cal_busy), 1);
        gpio_write(16'h0000, 8'h02);
        chk("final_idle", int'(cal_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
